// File: rtl/multicycle_alu.sv
`timescale 1ns/1ps
// multicycle_alu: handshaked execute ALU with registered results and iterative MUL/UDIV/UMOD.
// Define MULTICYCLE_ALU_DIV_EN to build the divider; without it UDIV/UMOD decode as unknown uops.
module multicycle_alu #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [4:0]       uop,
    input  logic [WIDTH-1:0] lhs,
    input  logic [WIDTH-1:0] rhs,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             out_wb,
    output logic [TAG_W-1:0] out_tag
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

    localparam logic [4:0] UOP_ADD  = 5'b00001;
    localparam logic [4:0] UOP_SUB  = 5'b00010;
    localparam logic [4:0] UOP_AND  = 5'b00011;
    localparam logic [4:0] UOP_XOR  = 5'b00100;
    localparam logic [4:0] UOP_CMP  = 5'b00101;
    localparam logic [4:0] UOP_LSL  = 5'b00110;
    localparam logic [4:0] UOP_LSR  = 5'b00111;
    localparam logic [4:0] UOP_MOV  = 5'b01000;
    localparam logic [4:0] UOP_STR  = 5'b01001;
    localparam logic [4:0] UOP_LDR  = 5'b01010;
    localparam logic [4:0] UOP_MUL  = 5'b01011;
    localparam logic [4:0] UOP_UDIV = 5'b01100;
    localparam logic [4:0] UOP_UMOD = 5'b01101;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [4:0]         op_q, op_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [2*WIDTH-1:0] work_q, work_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [3:0]         flags_q, flags_d;
    logic               wb_q, wb_d;
    logic [TAG_W-1:0]   tag_q, tag_d;

    logic               in_ready_s, accept_s;
    logic [WIDTH:0]     add_s, sub_s, shl_s;
    logic [WIDTH-1:0]   sc_res_s;
    logic               sc_c_s, sc_v_s, sc_wb_s, sc_multi_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_next_s, step_s;
    logic [WIDTH-1:0]   fin_res_s;
    logic               fin_c_s, fin_v_s;

    // Flags are packed {V,N,C,Z}, so Z lands in bit 0.
    function automatic logic [3:0] mk_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
        return {v, r[WIDTH-1], c, (r == {WIDTH{1'b0}})};
    endfunction

    // Single-cycle datapath and decode of which uops iterate.
    always_comb begin
        add_s      = {1'b0, lhs} + {1'b0, rhs};
        sub_s      = {1'b0, lhs} - {1'b0, rhs};
        shl_s      = {1'b0, lhs} << rhs;
        sc_res_s   = {WIDTH{1'b0}};
        sc_c_s     = 1'b0;
        sc_v_s     = 1'b0;
        sc_wb_s    = 1'b1;
        sc_multi_s = 1'b0;
        case (uop)
            UOP_ADD: begin
                sc_res_s = add_s[WIDTH-1:0];
                sc_c_s   = add_s[WIDTH];
                sc_v_s   = (lhs[WIDTH-1] == rhs[WIDTH-1]) && (add_s[WIDTH-1] != lhs[WIDTH-1]);
            end
            UOP_SUB, UOP_CMP: begin
                sc_res_s = sub_s[WIDTH-1:0];
                sc_c_s   = sub_s[WIDTH];
                sc_v_s   = (lhs[WIDTH-1] != rhs[WIDTH-1]) && (sub_s[WIDTH-1] != lhs[WIDTH-1]);
                sc_wb_s  = (uop != UOP_CMP);
            end
            UOP_AND: sc_res_s = lhs & rhs;
            UOP_XOR: sc_res_s = lhs ^ rhs;
            UOP_LSL: begin
                sc_res_s = shl_s[WIDTH-1:0];
                sc_c_s   = shl_s[WIDTH];
            end
            UOP_LSR: sc_res_s = lhs >> rhs;
            UOP_MOV: sc_res_s = rhs;
            UOP_STR, UOP_LDR: sc_res_s = add_s[WIDTH-1:0];
            UOP_MUL: sc_multi_s = 1'b1;
`ifdef MULTICYCLE_ALU_DIV_EN
            UOP_UDIV, UOP_UMOD: sc_multi_s = 1'b1;
`endif
            default: sc_wb_s = 1'b0;
        endcase
    end

    // Shift-add multiply step: {partial product, remaining multiplier bits}.
    always_comb begin
        mul_sum_s  = {1'b0, work_q[2*WIDTH-1:WIDTH]} +
                     (work_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
        mul_next_s = {mul_sum_s, work_q[WIDTH-1:1]};
    end

`ifdef MULTICYCLE_ALU_DIV_EN
    logic [WIDTH:0]     div_trial_s;
    logic [WIDTH-1:0]   div_diff_s;
    logic               div_borrow_s;
    logic [2*WIDTH-1:0] div_next_s;

    // Restoring divide step: {remainder, dividend shifting out / quotient shifting in}.
    always_comb begin
        div_trial_s  = {work_q[2*WIDTH-1:WIDTH], work_q[WIDTH-1]};
        div_borrow_s = (div_trial_s < {1'b0, opnd_q});
        div_diff_s   = div_trial_s[WIDTH-1:0] - opnd_q;
        div_next_s   = {(div_borrow_s ? div_trial_s[WIDTH-1:0] : div_diff_s),
                        work_q[WIDTH-2:0], ~div_borrow_s};
    end
`endif

    // Selects the iteration step and the final result for the op in flight.
    always_comb begin
        step_s    = mul_next_s;
        fin_res_s = mul_next_s[WIDTH-1:0];
        fin_c_s   = |mul_next_s[2*WIDTH-1:WIDTH];
        fin_v_s   = 1'b0;
        case (op_q)
`ifdef MULTICYCLE_ALU_DIV_EN
            UOP_UDIV: begin
                step_s    = div_next_s;
                fin_res_s = div_next_s[WIDTH-1:0];
                fin_c_s   = 1'b0;
                fin_v_s   = (opnd_q == {WIDTH{1'b0}});
            end
            UOP_UMOD: begin
                step_s    = div_next_s;
                fin_res_s = div_next_s[2*WIDTH-1:WIDTH];
                fin_c_s   = 1'b0;
                fin_v_s   = (opnd_q == {WIDTH{1'b0}});
            end
`endif
            default: fin_v_s = 1'b0;
        endcase
    end

    // Next-state logic: acceptance reloads everything; otherwise iterate, hold or retire.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        opnd_d     = opnd_q;
        work_d     = work_q;
        result_d   = result_q;
        flags_d    = flags_q;
        wb_d       = wb_q;
        tag_d      = tag_q;
        in_ready_s = (state_q == IDLE) || ((state_q == DONE) && out_ready);
        accept_s   = in_valid && in_ready_s;
        if (accept_s) begin
            state_d  = sc_multi_s ? BUSY : DONE;
            cnt_d    = {CW{1'b0}};
            op_d     = uop;
            opnd_d   = rhs;
            work_d   = {{WIDTH{1'b0}}, lhs};
            result_d = sc_res_s;
            flags_d  = mk_flags(sc_res_s, sc_c_s, sc_v_s);
            wb_d     = sc_wb_s;
            tag_d    = in_tag;
        end else begin
            case (state_q)
                IDLE: state_d = IDLE;
                BUSY: begin
                    work_d = step_s;
                    cnt_d  = cnt_q + {{(CW-1){1'b0}}, 1'b1};
                    if (cnt_q == LAST_ITER) begin
                        state_d  = DONE;
                        cnt_d    = {CW{1'b0}};
                        result_d = fin_res_s;
                        flags_d  = mk_flags(fin_res_s, fin_c_s, fin_v_s);
                    end else begin
                        state_d = BUSY;
                    end
                end
                DONE:    state_d = out_ready ? IDLE : DONE;
                default: state_d = IDLE;
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= {CW{1'b0}};
            op_q     <= 5'b00000;
            opnd_q   <= {WIDTH{1'b0}};
            work_q   <= {(2*WIDTH){1'b0}};
            result_q <= {WIDTH{1'b0}};
            flags_q  <= 4'b0000;
            wb_q     <= 1'b0;
            tag_q    <= {TAG_W{1'b0}};
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            opnd_q   <= opnd_d;
            work_q   <= work_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            wb_q     <= wb_d;
            tag_q    <= tag_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign flags     = flags_q;
    assign out_wb    = wb_q;
    assign out_tag   = tag_q;

endmodule

// File: tb/tb_multicycle_alu.sv
`timescale 1ns/1ps
// Scoreboard bench for multicycle_alu: directed scenarios then randomized ops with random back-pressure.
module tb_multicycle_alu;
    localparam logic [4:0] U_ADD = 5'd1, U_SUB = 5'd2, U_CMP = 5'd5, U_LSL = 5'd6;
    localparam logic [4:0] U_MUL = 5'd11, U_UDIV = 5'd12, U_UMOD = 5'd13;
`ifdef MULTICYCLE_ALU_DIV_EN
    localparam int DIV_LAT = 33;
`else
    localparam int DIV_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, out_wb;
    logic [4:0]  uop;
    logic [31:0] lhs, rhs, result;
    logic [3:0]  in_tag, out_tag, flags;
    logic        rnd_ready;
    int          n_vec = 0, n_err = 0, cyc = 0;

    typedef struct packed {
        logic [31:0] r;
        logic [3:0]  f;
        logic        wb;
        logic [3:0]  tag;
    } exp_t;
    exp_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multicycle_alu #(.WIDTH(32), .TAG_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .uop(uop),
        .lhs(lhs), .rhs(rhs), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .flags(flags), .out_wb(out_wb), .out_tag(out_tag)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", name, got, want);
        end
    endtask

    // Reference model straight from the uop definitions, using 64-bit arithmetic.
    function automatic exp_t model(input logic [4:0] u, input logic [31:0] a, input logic [31:0] b,
                                   input logic [3:0] t);
        exp_t        m;
        logic [63:0] w;
        longint      s;
        logic [31:0] r;
        logic        c, v, wb;
        r = 32'd0; c = 1'b0; v = 1'b0; wb = 1'b1;
        case (u)
            5'd1: begin
                w = {32'd0, a} + {32'd0, b}; r = w[31:0]; c = w[32];
                s = longint'($signed(a)) + longint'($signed(b));
                v = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000);
            end
            5'd2, 5'd5: begin
                r = a - b; c = (a < b);
                s = longint'($signed(a)) - longint'($signed(b));
                v = (s > 64'sh7FFFFFFF) || (s < -64'sh80000000);
                wb = (u != 5'd5);
            end
            5'd3: r = a & b;
            5'd4: r = a ^ b;
            5'd6: if (b <= 32'd32) begin w = {32'd0, a} << b; r = w[31:0]; c = w[32]; end
            5'd7: r = (b >= 32'd32) ? 32'd0 : (a >> b);
            5'd8: r = b;
            5'd9, 5'd10: r = a + b;
            5'd11: begin w = 64'(a) * 64'(b); r = w[31:0]; c = (w[63:32] != 32'd0); end
`ifdef MULTICYCLE_ALU_DIV_EN
            5'd12: begin r = (b == 32'd0) ? 32'hFFFF_FFFF : a / b; v = (b == 32'd0); end
            5'd13: begin r = (b == 32'd0) ? a : a % b; v = (b == 32'd0); end
`endif
            default: wb = 1'b0;
        endcase
        m.r = r; m.f = {v, r[31], c, (r == 32'd0)}; m.wb = wb; m.tag = t;
        return m;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    // Monitor: pops the oldest expectation on every completed output handshake.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++; n_err++;
                    $display("FAIL sb_unexpected: got result %h tag %0d, want no output", result, out_tag);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_result", 64'({result, flags, out_wb, out_tag}), 64'(e));
                end
            end
        end
    end

    // Call at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic issue(input logic [4:0] u, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] t, output int acc);
        uop = u; lhs = a; rhs = b; in_tag = t; in_valid = 1'b1; acc = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (in_ready) begin
                acc = cyc;
                exp_q.push_back(model(u, a, b, t));
                break;
            end
            @(posedge clk); #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
        end
        if (acc < 0) begin
            n_vec++; n_err++;
            $display("FAIL issue_timeout: got in_ready low for 300 cycles, want acceptance");
        end
        @(posedge clk); #1;
        in_valid = 1'b0; lhs = $urandom; rhs = $urandom; uop = 5'($urandom); in_tag = 4'($urandom);
        if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic wait_valid(output int lat, input logic chk_busy);
        lat = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
            if (chk_busy) check("busy_in_ready", 64'(in_ready), 64'd0);
        end
        @(posedge clk); #1;
    endtask

    initial begin : stim
        int   a0, a1, a2, lat;
        exp_t he;
        rst = 1'b1; in_valid = 1'b0; uop = 5'd0; lhs = 32'd0; rhs = 32'd0; in_tag = 4'd0;
        out_ready = 1'b1; rnd_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_state", 64'({in_ready, out_valid, result, flags, out_wb, out_tag}),
              64'({1'b1, 1'b0, 32'd0, 4'd0, 1'b0, 4'd0}));
        // Reset and a valid op on the same edge: nothing may be accepted.
        @(posedge clk); #1;
        in_valid = 1'b1; uop = U_ADD; lhs = 32'd1; rhs = 32'd1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("rst_wins", 64'(out_valid), 64'd0);
        @(posedge clk); #1;

        issue(U_ADD, 32'hFFFF_FFFF, 32'd1, 4'd3, a0);
        wait_valid(lat, 1'b0);
        check("add_latency", 64'(lat), 64'd1);
        issue(U_SUB, 32'h8000_0000, 32'd1, 4'd0, a0);
        issue(U_CMP, 32'd5, 32'd5, 4'd1, a0);
        wait_valid(lat, 1'b0);
        issue(U_MUL, 32'h0001_0000, 32'h0001_0000, 4'd5, a0);
        wait_valid(lat, 1'b1);
        check("mul_latency", 64'(lat), 64'd33);
        issue(U_UDIV, 32'd100, 32'd7, 4'd6, a0);
        wait_valid(lat, DIV_LAT != 1);
        check("udiv_latency", 64'(lat), 64'(DIV_LAT));
        issue(U_UMOD, 32'd100, 32'd7, 4'd7, a0);
        wait_valid(lat, 1'b0);
        issue(U_UDIV, 32'd5, 32'd0, 4'd8, a0);
        wait_valid(lat, 1'b0);

        issue(U_ADD, 32'd1, 32'd2, 4'd1, a0);
        issue(U_ADD, 32'd3, 32'd4, 4'd2, a1);
        issue(U_ADD, 32'h7FFF_FFFF, 32'd1, 4'd3, a2);
        check("b2b_throughput", 64'(a2 - a0), 64'd2);
        repeat (3) @(posedge clk); #1;

        out_ready = 1'b0;
        issue(U_ADD, 32'h1234_5678, 32'h1111_1111, 4'd9, a0);
        wait_valid(lat, 1'b0);
        he = model(U_ADD, 32'h1234_5678, 32'h1111_1111, 4'd9);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("hold_stable", 64'({out_valid, in_ready, result, flags, out_wb, out_tag}),
                  64'({1'b1, 1'b0, he.r, he.f, he.wb, he.tag}));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Reset lands on the 10th BUSY edge of a multiply.
        issue(U_MUL, 32'd3, 32'd5, 4'd7, a0);
        repeat (9) @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        check("rst_mid_mul", 64'({out_valid, in_ready, flags}), 64'({1'b0, 1'b1, 4'b0000}));
        @(posedge clk); #1;
        issue(U_LSL, 32'h8000_0000, 32'd1, 4'd2, a0);
        wait_valid(lat, 1'b0);

        rnd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [4:0]  u;
            logic [31:0] a, b;
            u = 5'($urandom_range(0, 15));
            a = pick_operand();
            b = (u == 5'd6 || u == 5'd7) ? 32'($urandom_range(0, 40)) : pick_operand();
            issue(u, a, b, 4'($urandom), a0);
        end
        rnd_ready = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk); #1;
        end
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/multicycle_alu.md
Name: multicycle_alu

Overview:
Parametrised, handshaked successor to the combinational execute ALU in the CPU datapath. Keeps the existing 5-bit micro-op encoding and [Z,C,N,V] flag order. Adds registered results, valid/ready flow control, and iterative multi-cycle MUL/UDIV/UMOD. Sits between decode/operand fetch and writeback; results leave only through the output handshake.

Parameters:
WIDTH, 32, operand/result width; power of 2, minimum 8.
TAG_W, 4, width of the opaque tag carried from input to output (destination register id).

Ports:
clk  input  1  single clock; everything is sampled on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operation presented.
in_ready  output  1  block can accept an operation this cycle.
uop  input  5  micro-op.
lhs  input  WIDTH  left-hand operand.
rhs  input  WIDTH  right-hand operand.
in_tag  input  TAG_W  tag, returned unchanged with the result.
out_valid  output  1  result, flags and tag are valid.
out_ready  input  1  consumer accepts the result.
result  output  WIDTH  registered result.
flags  output  4  registered [Z,C,N,V], with bit 0 = Z.
out_wb  output  1  1 = result is to be written to the register file; 0 for CMP only.
out_tag  output  TAG_W  registered tag.

Behaviour:
- Reset values: in_ready=1, out_valid=0, result=0, flags=0000, out_wb=0, out_tag=0, state=IDLE, iteration counter=0. Reset mid-operation discards the in-flight op; there is no partial result.
- States:
  - IDLE: in_ready=1.
  - BUSY: in_ready=0.
  - DONE: out_valid=1; in_ready=out_ready.
- Acceptance: in_valid && in_ready on a rising edge (edge T0). Operands, uop and tag are captured at T0 only; input changes afterwards are ignored.
- Single-cycle ops: result registered at T0, state goes to DONE, out_valid is high in the next cycle.
- Multi-cycle ops: BUSY for exactly WIDTH cycles (one iteration per edge, T0+1..T0+WIDTH), then DONE after edge T0+WIDTH.
- DONE with out_ready=0: result, flags, out_wb and out_tag are held stable.
- DONE with out_ready=1:
  - with in_valid: accept the next op in the same edge (single-cycle op gives throughput of 1 per cycle);
  - without in_valid: go to IDLE.
- Uops:
  - 00001 ADD: C = carry out of bit WIDTH-1; V = signed overflow.
  - 00010 SUB and 00101 CMP: C = borrow (bit WIDTH of the (WIDTH+1)-bit difference); V = signed overflow. CMP drives out_wb=0.
  - 00011 AND, 00100 XOR: C=V=0.
  - 00110 LSL: shift amount is the full rhs. C = bit WIDTH of ({1'b0,lhs} << rhs), which is 0 for an amount of 0 or above WIDTH. An amount of WIDTH or more gives result 0.
  - 00111 LSR: amount of WIDTH or more gives 0; C=0.
  - 01000 MOV: result = rhs.
  - 01001 STR, 01010 LDR: result = lhs+rhs; C=V=0.
  - 01011 MUL: shift-add. result = low WIDTH bits; C = 1 if the high WIDTH bits are nonzero; V=0.
  - 01100 UDIV and 01101 UMOD: restoring division. UDIV returns the quotient, UMOD the remainder; C=V=0.
  - Divide by zero: UDIV returns all-ones, UMOD returns lhs; V=1.
  - Any other uop: single-cycle, result 0, C=V=0, out_wb=0.
- For every op: Z = (result==0) and N = result[WIDTH-1]. For CMP these are computed from the difference.
- Counter width is $clog2(WIDTH)+1; it counts WIDTH iterations and must not wrap early.
- Simultaneous rst and in_valid: rst wins and nothing is accepted.

Optional Feature:
MULTICYCLE_ALU_DIV_EN.
- Defined: UDIV/UMOD implemented as specified above.
- Undefined: the divider datapath is removed. 01100 and 01101 are treated as unknown uops (single-cycle, result 0, out_wb=0). MUL is unaffected.

Test Plan:
1. ADD 0xFFFFFFFF+0x00000001, tag 3 -> result 0x00000000, Z=1 C=1 N=0 V=0, out_tag 3. out_valid high in the cycle after acceptance.
2. SUB 0x80000000-0x00000001 -> 0x7FFFFFFF, Z=0 C=0 N=0 V=1. CMP 5,5 -> Z=1, C=0, out_wb=0.
3. MUL 0x00010000*0x00010000 -> result 0, Z=1 C=1. out_valid rises exactly 32 cycles later than for an ADD accepted at the same edge; in_ready=0 throughout BUSY.
4. UDIV 100/7 -> 14; UMOD 100/7 -> 2; UDIV 5/0 -> 0xFFFFFFFF with V=1. Without the macro, UDIV 100/7 -> 0 in single-cycle latency.
5. Three back-to-back ADDs with out_ready=1 -> one result per cycle, in order. Hold out_ready=0 for 4 cycles -> result, flags and tag stable; in_ready=0.
6. Assert rst during cycle 10 of a MUL -> next cycle out_valid=0, in_ready=1, flags=0000. A following LSL 0x80000000 by 1 -> result 0, C=1, Z=1.
